// File: rtl/genesis_pad_responder.sv
// Genesis-style control pad responder: answers the console's select line with
// the three- or six-button multiplexed pattern on registered active-low pins.
module genesis_pad_responder #(
    parameter int TIMEOUT_CYCLES = 75000,
    parameter bit SIX_BUTTON     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [11:0] buttons,
    output logic        pin0,
    output logic        pin1,
    output logic        pin2,
    output logic        pin3,
    output logic        pin5,
    output logic        pin8,
    output logic [2:0]  phase
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic          sel_meta, sel_sync, sel_prev;
    logic [11:0]   btn_meta, btn_sync;
    logic [2:0]    p, p_next;
    logic [TW-1:0] t, t_next;
    logic          fall, rise, timeout;
    // packed as {pin8, pin5, pin3, pin2, pin1, pin0}
    logic [5:0]    pins_next, pins_q;

    // Two-flop synchronizers; sel history idles high so reset release never fakes an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_meta <= 1'b1;
            sel_sync <= 1'b1;
            sel_prev <= 1'b1;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sel_meta <= sel;
            sel_sync <= sel_meta;
            sel_prev <= sel_sync;
            btn_meta <= buttons;
            btn_sync <= btn_meta;
        end
    end

    assign fall    = sel_prev & ~sel_sync;
    assign rise    = ~sel_prev & sel_sync;
    assign timeout = (t == T_MAX);

    // Phase and idle counters; a falling edge beats a simultaneous timeout
    always_comb begin
        t_next = t;
        p_next = p;
        if (fall || rise)
            t_next = '0;
        else if (!timeout)
            t_next = t + TW'(1);

        if (!SIX_BUTTON)
            p_next = 3'd0;
        else if (fall) begin
            if (p == 3'd4)
                p_next = timeout ? 3'd1 : 3'd4;
            else
                p_next = p + 3'd1;
        end else if (timeout)
            p_next = 3'd0;
    end

    // Pin pattern chosen from the freshly updated phase so the ID lands on the third low phase
    always_comb begin
        pins_next = 6'b111111;
        if (sel_sync) begin
            pins_next[5] = ~btn_sync[6];
            pins_next[4] = ~btn_sync[5];
            if (p_next == 3'd3)
                pins_next[3:0] = {~btn_sync[11], ~btn_sync[8], ~btn_sync[9], ~btn_sync[10]};
            else
                pins_next[3:0] = ~btn_sync[3:0];
        end else begin
            pins_next[5] = ~btn_sync[7];
            pins_next[4] = ~btn_sync[4];
            case (p_next)
                3'd3:    pins_next[3:0] = 4'b0000;
                3'd4:    pins_next[3:0] = 4'b1111;
                default: pins_next[3:0] = {2'b00, ~btn_sync[1], ~btn_sync[0]};
            endcase
        end
    end

    // State and output registers; reset parks every pin released (high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p      <= 3'd0;
            t      <= '0;
            pins_q <= 6'b111111;
        end else begin
            p      <= p_next;
            t      <= t_next;
            pins_q <= pins_next;
        end
    end

    assign {pin8, pin5, pin3, pin2, pin1, pin0} = pins_q;
    assign phase = p;

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Directed bench for genesis_pad_responder: a six-button instance and a
// three-button instance share stimulus; expected pin patterns are hand-computed.
module tb_genesis_pad_responder;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b1;
    logic [11:0] buttons = 12'hFFF;

    logic a0, a1, a2, a3, a5, a8;
    logic b0, b1, b2, b3, b5, b8;
    logic [2:0] ph6, ph3;
    logic [5:0] pins6, pins3;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        s;
        logic [11:0] btn;
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs[10];

    genesis_pad_responder #(.TIMEOUT_CYCLES(TO), .SIX_BUTTON(1'b1)) dut6 (
        .clk(clk), .reset(reset), .sel(sel), .buttons(buttons),
        .pin0(a0), .pin1(a1), .pin2(a2), .pin3(a3), .pin5(a5), .pin8(a8),
        .phase(ph6)
    );

    genesis_pad_responder #(.TIMEOUT_CYCLES(TO), .SIX_BUTTON(1'b0)) dut3 (
        .clk(clk), .reset(reset), .sel(sel), .buttons(buttons),
        .pin0(b0), .pin1(b1), .pin2(b2), .pin3(b3), .pin5(b5), .pin8(b8),
        .phase(ph3)
    );

    assign pins6 = {a8, a5, a3, a2, a1, a0};
    assign pins3 = {b8, b5, b3, b2, b1, b0};

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [11:0] btn);
        buttons = btn;
        sel = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    // One 1 us select period on the six-button unit: 25 cycles low, 25 high
    task automatic pulse6(input int i, input logic [5:0] exp_lo, input logic [5:0] exp_hi);
        sel = 1'b0;
        tick(2);
        chk("six_phase_hold", {5'b0, ph6}, 8'(i - 1));
        tick(1);
        chk("six_phase", {5'b0, ph6}, 8'(i));
        chk("six_low_pins", {2'b0, pins6}, {2'b0, exp_lo});
        tick(22);
        sel = 1'b1;
        tick(3);
        chk("six_high_pins", {2'b0, pins6}, {2'b0, exp_hi});
        tick(22);
    endtask

    task automatic six_sequence();
        pulse6(1, 6'b110011, 6'b111111);
        pulse6(2, 6'b110011, 6'b111111);
        pulse6(3, 6'b110000, 6'b111110);
        pulse6(4, 6'b111111, 6'b111111);
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'h021, 6'b101110};
        vecs[1] = '{1'b0, 12'h021, 6'b110010};
        vecs[2] = '{1'b1, 12'h000, 6'b111111};
        vecs[3] = '{1'b0, 12'h000, 6'b110011};
        vecs[4] = '{1'b1, 12'h0CC, 6'b010011};
        vecs[5] = '{1'b0, 12'h092, 6'b000001};
        vecs[6] = '{1'b1, 12'h092, 6'b111101};
        vecs[7] = '{1'b1, 12'hF00, 6'b111111};
        vecs[8] = '{1'b0, 12'hFFF, 6'b000000};
        vecs[9] = '{1'b1, 12'hFFF, 6'b000000};

        // Reset held with everything pressed and sel toggling
        #1;
        for (int i = 0; i < 10; i++) begin
            sel = ~sel;
            tick(1);
            chk("rst_pins6", {2'b0, pins6}, 8'h3F);
            chk("rst_pins3", {2'b0, pins3}, 8'h3F);
            chk("rst_phase6", {5'b0, ph6}, 8'h00);
        end

        // Table-driven three-button reads on the SIX_BUTTON=0 unit (phase always 0)
        do_reset(12'h000);
        chk("idle_pins3", {2'b0, pins3}, 8'h3F);
        for (int i = 0; i < 10; i++) begin
            logic [5:0] prev;
            prev = (i == 0) ? 6'b111111 : vecs[i-1].exp;
            sel = vecs[i].s;
            buttons = vecs[i].btn;
            tick(2);
            chk("vec_latency", {2'b0, pins3}, {2'b0, prev});
            tick(1);
            chk("vec_pins", {2'b0, pins3}, {2'b0, vecs[i].exp});
            tick(5);
        end

        // Six-button sequence with Z pressed, then timeout back to phase 0
        do_reset(12'h400);
        chk("six_idle", {2'b0, pins6}, 8'h3F);
        six_sequence();
        tick(75);
        chk("timeout_early", {5'b0, ph6}, 8'd4);
        tick(5);
        chk("timeout_phase", {5'b0, ph6}, 8'd0);
        sel = 1'b0;
        tick(3);
        chk("post_to_phase", {5'b0, ph6}, 8'd1);
        chk("post_to_pins", {2'b0, pins6}, 8'b110011);
        tick(22);
        sel = 1'b1;
        tick(25);

        // Falling edge lands in the cycle the idle counter sits at its limit with p=4
        do_reset(12'h400);
        six_sequence();
        tick(75);
        sel = 1'b0;
        tick(3);
        chk("coll_phase", {5'b0, ph6}, 8'd1);
        chk("coll_pins", {2'b0, pins6}, 8'b110011);
        tick(87);
        chk("coll_t_cleared", {5'b0, ph6}, 8'd1);

        // Asynchronous reset mid-sequence
        #5;
        reset = 1'b1;
        #1;
        chk("async_rst_pins", {2'b0, pins6}, 8'h3F);
        chk("async_rst_phase", {5'b0, ph6}, 8'd0);
        tick(2);
        sel = 1'b1;
        reset = 1'b0;
        tick(6);
        chk("rst_release_phase", {5'b0, ph6}, 8'd0);
        chk("rst_release_pins", {2'b0, pins6}, 8'h3F);

        // Three-button unit: five low pulses never advance phase or show the ID
        do_reset(12'h400);
        for (int i = 0; i < 5; i++) begin
            sel = 1'b0;
            tick(3);
            chk("three_phase", {5'b0, ph3}, 8'd0);
            chk("three_low_pins", {2'b0, pins3}, 8'b110011);
            tick(22);
            sel = 1'b1;
            tick(3);
            chk("three_high_pins", {2'b0, pins3}, 8'h3F);
            tick(22);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/genesis_pad_responder.md
GENESIS_PAD_RESPONDER -- requirements
Module: genesis_pad_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 75000, meaning the idle clock count (1.5 ms at 50 MHz) after which the select-phase counter clears.
REQ-002 SHALL have parameter SIX_BUTTON, default 1; 1 gives six-button behaviour, 0 gives three-button behaviour only.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sel, input, 1, select line driven by the console; asynchronous to clk.
REQ-006 SHALL have port buttons, input, 12, active-high presses: [0] up, [1] down, [2] left, [3] right, [4] A, [5] B, [6] C, [7] Start, [8] X, [9] Y, [10] Z, [11] Mode.
REQ-007 SHALL have ports pin0, pin1, pin2, pin3, output, 1 each, active-low data lines.
REQ-008 SHALL have ports pin5 and pin8, output, 1 each, active-low: pin5 carries the A/B line and pin8 the Start/C line.
REQ-009 SHALL have port phase, output, 3, debug copy of the phase counter p.

Function
REQ-010 SHALL pass sel and buttons through 2-flop synchronizers; sel sync flops reset to 1, button sync flops reset to 0.
REQ-011 SHALL detect a falling edge of sel when the synced value is 0 and its previous value was 1, and a rising edge on the opposite transition.
REQ-012 SHALL keep phase counter p in 0..4; on each falling edge, p<=p+1, saturating at 4; when SIX_BUTTON=0, p stays 0.
REQ-013 SHALL keep idle counter t; it clears on any sel edge, otherwise increments, and saturates at TIMEOUT_CYCLES-1.
REQ-014 SHALL clear p to 0 in the cycle t reaches TIMEOUT_CYCLES-1; if a falling edge occurs in that same cycle, the edge wins: p<=1 when p was 4, else p+1, and t clears.
REQ-015 SHALL, with synced sel=1 and p!=3, drive pin0..3 = ~up, ~down, ~left, ~right, pin5 = ~B, pin8 = ~C.
REQ-016 SHALL, with synced sel=1 and p=3, drive pin0..3 = ~Z, ~Y, ~X, ~Mode, pin5 = ~B, pin8 = ~C.
REQ-017 SHALL, with synced sel=0 and p in {0,1,2}, drive pin0 = ~up, pin1 = ~down, pin2 = 0, pin3 = 0, pin5 = ~A, pin8 = ~Start.
REQ-018 SHALL, with synced sel=0 and p=3, drive pin0..3 = 0,0,0,0 (six-button ID), pin5 = ~A, pin8 = ~Start.
REQ-019 SHALL, with synced sel=0 and p=4, drive pin0..3 = 1,1,1,1, pin5 = ~A, pin8 = ~Start.
REQ-020 SHALL register all pin outputs, giving latency of 3 clk cycles from a sel transition to the matching output: 2 sync cycles plus 1 output register.
REQ-021 SHALL apply a button change to the outputs 3 cycles after the change.
REQ-022 SHALL compute output selection from the p value updated in the same cycle the edge is detected, so the ID pattern appears on the third low phase itself.

Reset
REQ-023 SHALL, on reset assertion at any time and mid-sequence included, immediately force pin0..3, pin5 and pin8 to 1, p=0, t=0 and phase=0.
REQ-024 SHALL, after reset deassertion, resume normal operation on the first rising clk edge, with the sel history treated as 1 so no spurious edge occurs.

Verification
REQ-025 Bench SHALL cover reset: reset=1 with buttons=12'hFFF and sel toggling -> all pins 1 and phase=0 throughout.
REQ-026 Bench SHALL cover three-button read: buttons=12'h021 (up+B); sel=1 -> pin0=0, pin5=0, others 1; sel=0 -> pin0=0, pin2=0, pin3=0, pin5=1, pin8=1; each result 3 cycles after the sel change.
REQ-027 Bench SHALL cover the six-button sequence: four low pulses at 1 us spacing with buttons=12'h400 (Z) -> low phase 3 gives pins0..3=0000; following high phase gives pin0=0; low phase 4 gives pins0..3=1111; phase reads 1,2,3,4.
REQ-028 Bench SHALL cover timeout: after the sequence, hold sel=1 for TIMEOUT_CYCLES cycles -> phase=0; next low phase gives normal three-button output.
REQ-029 Bench SHALL cover timeout/edge collision: falling edge in the cycle t=TIMEOUT_CYCLES-1 with p=4 -> p=1 and t=0.
REQ-030 Bench SHALL cover SIX_BUTTON=0: five low pulses -> phase stays 0 and the ID pattern never appears.
